// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared loader constants and FSM state encoding
package imem_boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/boot_word_packer.sv
// rtl/boot_word_packer.sv - packs a byte stream MSB first into 32-bit words
module boot_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] cnt;

  // Shift each accepted byte in from the bottom so the first byte ends up as the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (byte_valid) begin
      cnt  <= cnt + 2'd1;
      word <= {word[23:0], byte_data};
    end
  end

  assign word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - instruction memory boot loader; optional BOOT_CHECKSUM_EN adds an XOR checksum byte
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Largest word count that fits without the address wrapping.
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHECK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t            state;
  state_t            state_n;
  logic [7:0]        len_hi;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] index;
  logic              xfer;
  logic              idle_state;
  logic              start_ok;
  logic              data_xfer;
  logic              word_valid;
  logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer       = in_valid && in_ready;
  assign idle_state = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start_ok   = start && idle_state;
  assign data_xfer  = xfer && (state == S_DATA);
  assign len_full   = {len_hi, in_data};

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (data_xfer),
    .byte_data  (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; a start outside the idle states is simply not decoded.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_LEN_HI;
      S_LEN_HI: if (xfer) state_n = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if ({16'b0, len_full} > MAX_WORDS) state_n = S_ERROR;
          else if (len_full == '0)           state_n = S_FINISH;
          else                               state_n = S_DATA;
        end
      end
      S_DATA:  if (word_valid) state_n = S_WRITE;
      S_WRITE: state_n = (remaining == LEN_W'(1)) ? S_FINISH : S_DATA;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK: if (xfer) state_n = (in_data == csum) ? S_DONE : S_ERROR;
`else
      S_CHECK: state_n = S_ERROR;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Decoded outputs; done/err/cpu_run drop in the same cycle a start is seen.
  always_comb begin
    in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) || (state == S_CHECK);
    busy      = in_ready || (state == S_WRITE);
    mem_we    = (state == S_WRITE);
    mem_addr  = index;
    mem_wdata = DATA_W'(word);
    done      = (state == S_DONE) && !start;
    cpu_run   = (state == S_DONE) && !start;
    err       = (state == S_ERROR) && !start;
  end

  // Length capture, word countdown and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi    <= '0;
      remaining <= '0;
      index     <= '0;
    end else begin
      if (start_ok) begin
        remaining <= '0;
        index     <= '0;
      end
      if (xfer && (state == S_LEN_HI)) len_hi <= in_data;
      if (xfer && (state == S_LEN_LO)) remaining <= len_full;
      if (state == S_WRITE) begin
        remaining <= remaining - LEN_W'(1);
        index     <= index + ADDR_W'(1);
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR of data bytes only; length bytes are not covered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum <= '0;
    else if (start_ok)  csum <= '0;
    else if (data_xfer) csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic prev_we = 1'b0;
  logic [39:0] exp_q[$];
  logic [31:0] img[256];

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we pops the scoreboard and must last one cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      tests++;
      assert (prev_we === 1'b0) else begin
        fails++;
        $error("FAIL we_one_cycle observed=%0b expected=0", prev_we);
      end
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        logic [39:0] e;
        e = exp_q.pop_front();
        tests++;
        assert ({mem_addr, mem_wdata} === e) else begin
          fails++;
          $error("FAIL write observed=%0h_%0h expected=%0h_%0h", mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    if (gap) @(negedge clk);
  endtask

  // Start pulse from an idle state: status flags must drop while start is high.
  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    #1;
    check({tag, "_start_drop"}, {61'b0, cpu_run, done, err}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_busy"}, {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (done || err) break;
    end
  endtask

  task automatic send_word(input int idx, input bit gap, inout logic [7:0] cs);
    logic [31:0] w;
    w = img[idx];
    exp_q.push_back({8'(idx), w});
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8], gap);
      cs = cs ^ w[k*8 +: 8];
    end
  endtask

  // Full load of img[0..n-1]; csum_adj corrupts the checksum byte when nonzero.
  task automatic run_load(input string tag, input int n, input bit gap, input logic [7:0] csum_adj,
                          input logic [3:0] exp_status);
    logic [7:0] cs;
    cs = 8'h00;
    pulse_start(tag);
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) send_word(i, gap, cs);
`ifdef BOOT_CHECKSUM_EN
    send_byte(cs ^ csum_adj, gap);
`else
    cs = cs ^ csum_adj;
`endif
    wait_end();
    check({tag, "_status"}, {60'b0, done, err, cpu_run, busy}, {60'b0, exp_status});
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w0;
    logic [7:0] cs;

    // Reset state.
    #2;
    check("reset_outputs", {18'b0, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_outputs", {58'b0, in_ready, mem_we, cpu_run, busy, done, err}, 64'd0);

    // 1: basic two-word load.
    img[0] = 32'h12345678;
    img[1] = 32'h9ABCDEF0;
    run_load("t1", 2, 1'b0, 8'h00, 4'b1010);
    check("t1_writes", 64'(wr_cnt), 64'd2);
    check("t1_done_not_ready", {63'b0, in_ready}, 64'd0);

    // 2: same load with in_valid toggling.
    run_load("t2", 2, 1'b1, 8'h00, 4'b1010);
    check("t2_writes", 64'(wr_cnt), 64'd4);

    // 3: oversize length rejected before any write.
    w0 = wr_cnt;
    pulse_start("t3");
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end();
    check("t3_status", {60'b0, done, err, cpu_run, busy}, 64'b0100);
    repeat (3) @(negedge clk);
    check("t3_no_write", 64'(wr_cnt - w0), 64'd0);
    check("t3_err_not_ready", {63'b0, in_ready}, 64'd0);

    // Boundary: N equal to memory depth is accepted and fills every address.
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    run_load("tmax", 256, 1'b0, 8'h00, 4'b1010);

    // Boundary: N == 0 finishes with no write.
    w0 = wr_cnt;
    run_load("tzero", 0, 1'b0, 8'h00, 4'b1010);
    check("tzero_no_write", 64'(wr_cnt - w0), 64'd0);

    // 4: reset after six data bytes, then a fresh single-word load.
    img[0] = 32'h12345678;
    img[1] = 32'h9ABCDEF0;
    cs = 8'h00;
    pulse_start("t4");
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(0, 1'b0, cs);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_outputs", {18'b0, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, done, err}, 64'd0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    img[0] = 32'hDEADBEEF;
    run_load("t4b", 1, 1'b0, 8'h00, 4'b1010);

    // 5: AA 55 0F F0 (XOR 00).
    img[0] = 32'hAA550FF0;
    run_load("t5", 1, 1'b0, 8'h00, 4'b1010);
`ifdef BOOT_CHECKSUM_EN
    run_load("t5_bad", 1, 1'b0, 8'h01, 4'b0100);
`endif

    // 6: start during DATA is ignored; later start from DONE reloads.
    img[0] = 32'h01020304;
    img[1] = 32'hA0B0C0D0;
    cs = 8'h00;
    pulse_start("t6");
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_q.push_back({8'd0, img[0]});
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("t6_busy_start", {62'b0, busy, in_ready}, 64'b11);
    @(negedge clk);
    start = 1'b0;
    cs = 8'h01 ^ 8'h02;
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    cs = cs ^ 8'h03 ^ 8'h04;
    send_word(1, 1'b0, cs);
`ifdef BOOT_CHECKSUM_EN
    send_byte(cs, 1'b0);
`endif
    wait_end();
    check("t6_status", {60'b0, done, err, cpu_run, busy}, 64'b1010);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    img[0] = 32'hCAFEF00D;
    run_load("t6b", 1, 1'b1, 8'h00, 4'b1010);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
